sram_bist: RTL and testbench

Built-in self-test sequencer for the 1M×8 external SRAM. Sits directly upstream of the SRAM access block (`sram_1Mx8`) and drives its request port. On start it writes an address-derived pattern to every location, reads every location back and compares. It reports pass/fail plus the first failing address and data, and shows the result on the board LED.

---
 rtl/sram_bist.sv | 234 +++++++++++++++++++++++
 tb/tb_sram_bist.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bist.sv
// sram_bist: write/read-back self-test sequencer driving the SRAM access block request port.
// Optional second pass with the inverted pattern is enabled by defining SRAM_BIST_INVERT_PASS_EN.
module sram_bist #(
    parameter int         ADDR_W    = 20,
    parameter int         DATA_W    = 8,
    parameter logic [7:0] SEED      = 8'hA5,
    parameter int         BLINK_BIT = 25
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    output logic              o_req_valid,
    input  logic              i_req_ready,
    output logic              o_req_we,
    output logic [ADDR_W-1:0] o_req_addr,
    output logic [DATA_W-1:0] o_req_wdata,
    input  logic              i_rsp_valid,
    input  logic [DATA_W-1:0] i_rsp_rdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [ADDR_W-1:0] o_fail_addr,
    output logic [DATA_W-1:0] o_fail_exp,
    output logic [DATA_W-1:0] o_fail_got,
    output logic              o_led
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Address bits above ADDR_W read as zero; ADDR_W is at most 20.
    function automatic logic [7:0] pattern_f(input logic [ADDR_W-1:0] a);
        logic [19:0] a20;
        a20 = 20'd0;
        a20[ADDR_W-1:0] = a;
        return a20[7:0] ^ a20[15:8] ^ {4'b0000, a20[19:16]} ^ SEED;
    endfunction

    state_t              state_r, state_nx_s;
    logic [ADDR_W-1:0]   addr_r, addr_nx_s;
    logic                pass2_r, pass2_nx_s;
    logic                done_r, done_nx_s;
    logic                pass_r, pass_nx_s;
    logic [ADDR_W-1:0]   fail_addr_r, fail_addr_nx_s;
    logic [7:0]          fail_exp_r, fail_exp_nx_s;
    logic [7:0]          fail_got_r, fail_got_nx_s;
    logic                req_valid_r, req_valid_nx_s;
    logic                req_we_r, req_we_nx_s;
    logic [7:0]          req_wdata_r, req_wdata_nx_s;
    logic                busy_r, busy_nx_s;
    logic                led_r, led_nx_s;
    logic [BLINK_BIT:0]  cnt_r, cnt_nx_s;
    logic                accept_s;
    logic                addr_last_s;
    logic [7:0]          exp_s;

    assign accept_s    = req_valid_r & i_req_ready;
    assign addr_last_s = &addr_r;
    assign exp_s       = pass2_r ? ~pattern_f(addr_r) : pattern_f(addr_r);
    assign cnt_nx_s    = cnt_r + (BLINK_BIT+1)'(1);

    // State and datapath registers, including every registered output.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r     <= ST_IDLE;
            addr_r      <= '0;
            pass2_r     <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            fail_addr_r <= '0;
            fail_exp_r  <= 8'h00;
            fail_got_r  <= 8'h00;
            req_valid_r <= 1'b0;
            req_we_r    <= 1'b0;
            req_wdata_r <= 8'h00;
            busy_r      <= 1'b0;
            led_r       <= 1'b0;
            cnt_r       <= '0;
        end else begin
            state_r     <= state_nx_s;
            addr_r      <= addr_nx_s;
            pass2_r     <= pass2_nx_s;
            done_r      <= done_nx_s;
            pass_r      <= pass_nx_s;
            fail_addr_r <= fail_addr_nx_s;
            fail_exp_r  <= fail_exp_nx_s;
            fail_got_r  <= fail_got_nx_s;
            req_valid_r <= req_valid_nx_s;
            req_we_r    <= req_we_nx_s;
            req_wdata_r <= req_wdata_nx_s;
            busy_r      <= busy_nx_s;
            led_r       <= led_nx_s;
            cnt_r       <= cnt_nx_s;
        end
    end

    // Next-state and result logic; end of a phase is detected by an all-ones address.
    always_comb begin
        state_nx_s     = state_r;
        addr_nx_s      = addr_r;
        pass2_nx_s     = pass2_r;
        done_nx_s      = done_r;
        pass_nx_s      = pass_r;
        fail_addr_nx_s = fail_addr_r;
        fail_exp_nx_s  = fail_exp_r;
        fail_got_nx_s  = fail_got_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    state_nx_s     = ST_WR;
                    addr_nx_s      = '0;
                    pass2_nx_s     = 1'b0;
                    done_nx_s      = 1'b0;
                    pass_nx_s      = 1'b0;
                    fail_addr_nx_s = '0;
                    fail_exp_nx_s  = 8'h00;
                    fail_got_nx_s  = 8'h00;
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_WR: begin
                if (accept_s) begin
                    if (addr_last_s) begin
                        state_nx_s = ST_RD;
                        addr_nx_s  = '0;
                    end else begin
                        addr_nx_s = addr_r + ADDR_W'(1);
                    end
                end else begin
                    state_nx_s = ST_WR;
                end
            end
            ST_RD: begin
                if (accept_s) begin
                    state_nx_s = ST_WAIT;
                end else begin
                    state_nx_s = ST_RD;
                end
            end
            ST_WAIT: begin
                if (i_rsp_valid) begin
                    if (i_rsp_rdata != exp_s) begin
                        state_nx_s     = ST_DONE;
                        done_nx_s      = 1'b1;
                        pass_nx_s      = 1'b0;
                        fail_addr_nx_s = addr_r;
                        fail_exp_nx_s  = exp_s;
                        fail_got_nx_s  = i_rsp_rdata;
                    end else if (addr_last_s) begin
`ifdef SRAM_BIST_INVERT_PASS_EN
                        if (!pass2_r) begin
                            state_nx_s = ST_WR;
                            addr_nx_s  = '0;
                            pass2_nx_s = 1'b1;
                        end else begin
                            state_nx_s = ST_DONE;
                            done_nx_s  = 1'b1;
                            pass_nx_s  = 1'b1;
                        end
`else
                        state_nx_s = ST_DONE;
                        done_nx_s  = 1'b1;
                        pass_nx_s  = 1'b1;
`endif
                    end else begin
                        state_nx_s = ST_RD;
                        addr_nx_s  = addr_r + ADDR_W'(1);
                    end
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from the upcoming state so they can be registered without extra latency.
    always_comb begin
        req_valid_nx_s = 1'b0;
        req_we_nx_s    = 1'b0;
        req_wdata_nx_s = 8'h00;
        busy_nx_s      = 1'b0;
        led_nx_s       = 1'b0;
        case (state_nx_s)
            ST_WR: begin
                req_valid_nx_s = 1'b1;
                req_we_nx_s    = 1'b1;
                req_wdata_nx_s = pass2_nx_s ? ~pattern_f(addr_nx_s) : pattern_f(addr_nx_s);
                busy_nx_s      = 1'b1;
                led_nx_s       = cnt_nx_s[BLINK_BIT-2];
            end
            ST_RD: begin
                req_valid_nx_s = 1'b1;
                busy_nx_s      = 1'b1;
                led_nx_s       = cnt_nx_s[BLINK_BIT-2];
            end
            ST_WAIT: begin
                busy_nx_s = 1'b1;
                led_nx_s  = cnt_nx_s[BLINK_BIT-2];
            end
            ST_DONE: begin
                if (pass_nx_s) begin
                    led_nx_s = 1'b1;
                end else begin
                    led_nx_s = cnt_nx_s[BLINK_BIT];
                end
            end
            default: begin
                led_nx_s = 1'b0;
            end
        endcase
    end

    assign o_req_valid = req_valid_r;
    assign o_req_we    = req_we_r;
    assign o_req_addr  = addr_r;
    assign o_req_wdata = req_wdata_r;
    assign o_busy      = busy_r;
    assign o_done      = done_r;
    assign o_pass      = pass_r;
    assign o_fail_addr = fail_addr_r;
    assign o_fail_exp  = fail_exp_r;
    assign o_fail_got  = fail_got_r;
    assign o_led       = led_r;

endmodule

// File: tb/tb_sram_bist.sv
// Self-checking bench for sram_bist: table of run scenarios, randomized memory model, reset corner cases.
module tb_sram_bist;
    localparam int AW = 4;
    localparam int N  = 16;
`ifdef SRAM_BIST_INVERT_PASS_EN
    localparam int NPASS = 2;
`else
    localparam int NPASS = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          req_ready = 1'b1;
    logic          rsp_valid = 1'b0;
    logic [7:0]    rsp_rdata = 8'h00;
    logic          req_valid, req_we, busy, done, pass_o, led;
    logic [AW-1:0] req_addr, fail_addr;
    logic [7:0]    req_wdata, fail_exp, fail_got;

    sram_bist #(.ADDR_W(AW), .DATA_W(8), .SEED(8'hA5), .BLINK_BIT(3)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .o_req_valid(req_valid), .i_req_ready(req_ready), .o_req_we(req_we),
        .o_req_addr(req_addr), .o_req_wdata(req_wdata),
        .i_rsp_valid(rsp_valid), .i_rsp_rdata(rsp_rdata),
        .o_busy(busy), .o_done(done), .o_pass(pass_o),
        .o_fail_addr(fail_addr), .o_fail_exp(fail_exp), .o_fail_got(fail_got), .o_led(led)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    // Reference pattern: plain arithmetic on the address, inverted in the second pass.
    function automatic logic [7:0] pat(input int a, input int p);
        logic [7:0] v;
        v = 8'((a & 255) ^ ((a >> 8) & 255) ^ ((a >> 16) & 15)) ^ 8'hA5;
        return (p == 2) ? ~v : v;
    endfunction

    // Memory model state
    logic [7:0] mem [N];
    int         wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    int         rd_addr_q[$];
    int         pend = 0;
    int         pend_addr = 0;
    logic       stall_en = 1'b0;
    int         max_lat = 1;
    int         flip_addr = -1;
    logic [7:0] flip_mask = 8'h00;
    int         flip_pass = 0;

    initial begin : mem_model
        logic          hs, hwe, prev_stall, prev_we;
        logic [AW-1:0] ha, prev_addr;
        logic [7:0]    hd, prev_wdata;
        int            wpass;
        prev_stall = 1'b0;
        prev_we = 1'b0;
        prev_addr = '0;
        prev_wdata = 8'h00;
        forever begin
            @(negedge clk);
            hs  = rst_n && req_valid && req_ready;
            hwe = req_we;
            ha  = req_addr;
            hd  = req_wdata;
            if (prev_stall && rst_n)
                check("stall_hold", 32'({req_valid, req_we, req_addr, req_wdata}),
                      32'({1'b1, prev_we, prev_addr, prev_wdata}));
            prev_stall = rst_n && req_valid && !req_ready;
            prev_we    = req_we;
            prev_addr  = req_addr;
            prev_wdata = req_wdata;
            @(posedge clk);
            #1;
            rsp_valid = 1'b0;
            if (!rst_n) begin
                pend = 0;
            end else begin
                if (hs) begin
                    if (hwe) begin
                        wpass = wr_addr_q.size() / N + 1;
                        mem[ha] = hd ^ ((int'(ha) == flip_addr && wpass == flip_pass) ? flip_mask : 8'h00);
                        wr_addr_q.push_back(int'(ha));
                        wr_data_q.push_back(hd);
                    end else begin
                        rd_addr_q.push_back(int'(ha));
                        pend = (max_lat > 1) ? int'($urandom_range(max_lat, 1)) : 1;
                        pend_addr = int'(ha);
                    end
                end
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        rsp_valid = 1'b1;
                        rsp_rdata = mem[pend_addr];
                    end
                end
            end
            req_ready = stall_en ? 1'($urandom_range(1, 0)) : 1'b1;
        end
    end

    typedef struct {
        string      name;
        bit         stall;
        int         lat;
        int         faddr;
        logic [7:0] fmask;
        int         fpass;
        bit         epass;
        int         efaddr;
        logic [7:0] eexp;
        logic [7:0] egot;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string nm, input bit st, input int lt, input int fa,
                                input logic [7:0] fm, input int fp, input bit ep,
                                input int efa, input logic [7:0] ee, input logic [7:0] eg);
        vec_t v;
        v.name = nm; v.stall = st; v.lat = lt; v.faddr = fa; v.fmask = fm; v.fpass = fp;
        v.epass = ep; v.efaddr = efa; v.eexp = ee; v.egot = eg;
        return v;
    endfunction

    task automatic pulse_start();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int cyc, ones, exp_wr, exp_rd, p;
        bit failed;
        stall_en = v.stall; max_lat = v.lat;
        flip_addr = v.faddr; flip_mask = v.fmask; flip_pass = v.fpass;
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
        pulse_start();
        check({v.name, ".start"}, 32'({busy, req_valid, req_we, req_addr, done}), 32'({1'b1, 1'b1, 1'b1, 4'd0, 1'b0}));
        cyc = 0;
        while (!done && cyc < 3000) begin
            @(posedge clk); #1; cyc++;
        end
        check({v.name, ".timeout"}, 32'(done), 32'd1);
        // expected traffic from the scenario rules
        exp_wr = 0; exp_rd = 0; failed = 1'b0; p = 1;
        while (p <= NPASS && !failed) begin
            exp_wr += N;
            for (int a = 0; a < N && !failed; a++) begin
                exp_rd++;
                if (a == v.faddr && p == v.fpass) failed = 1'b1;
            end
            p++;
        end
        if (!v.stall && v.lat == 1) check({v.name, ".cycles"}, 32'(cyc), 32'(exp_wr + 2 * exp_rd));
        check({v.name, ".pass"}, 32'(pass_o), 32'(v.epass));
        check({v.name, ".busy"}, 32'(busy), 32'd0);
        check({v.name, ".fail_addr"}, 32'(fail_addr), 32'(v.efaddr));
        check({v.name, ".fail_exp"}, 32'(fail_exp), 32'(v.eexp));
        check({v.name, ".fail_got"}, 32'(fail_got), 32'(v.egot));
        check({v.name, ".n_wr"}, 32'(wr_addr_q.size()), 32'(exp_wr));
        check({v.name, ".n_rd"}, 32'(rd_addr_q.size()), 32'(exp_rd));
        for (int i = 0; i < wr_addr_q.size() && i < exp_wr; i++) begin
            check({v.name, ".wr_addr"}, 32'(wr_addr_q[i]), 32'(i % N));
            check({v.name, ".wr_data"}, 32'(wr_data_q[i]), 32'(pat(i % N, i / N + 1)));
        end
        for (int i = 0; i < rd_addr_q.size() && i < exp_rd; i++)
            check({v.name, ".rd_addr"}, 32'(rd_addr_q[i]), 32'(i % N));
        if (v.epass) begin
            check({v.name, ".led_on"}, 32'(led), 32'd1);
        end else begin
            ones = 0;
            for (int i = 0; i < 16; i++) begin
                @(posedge clk); #1;
                if (led) ones++;
            end
            check({v.name, ".led_blink"}, 32'(ones), 32'd8);
        end
    endtask

    initial begin : main
        int cyc, idle_bad;
        vec_t rv;
        int ra, rp;
        logic [7:0] rm;

        vecs.push_back(mk("ideal", 1'b0, 1, -1, 8'h00, 0, 1'b1, 0, 8'h00, 8'h00));
        vecs.push_back(mk("flip5", 1'b0, 1, 5, 8'h01, 1, 1'b0, 5, 8'hA0, 8'hA1));
        vecs.push_back(mk("stall", 1'b1, 4, -1, 8'h00, 0, 1'b1, 0, 8'h00, 8'h00));
        vecs.push_back(mk("stall_flip12", 1'b1, 3, 12, 8'h80, 1, 1'b0, 12, 8'hA9, 8'h29));
`ifdef SRAM_BIST_INVERT_PASS_EN
        vecs.push_back(mk("flip2_p2", 1'b0, 1, 2, 8'h01, 2, 1'b0, 2, 8'h58, 8'h59));
`endif

        // Reset held, then released with no start
        #2;
        check("rst.outputs", 32'({req_valid, req_we, busy, done, pass_o, led, req_addr, req_wdata}), 32'd0);
        #21 rst_n = 1'b1;
        idle_bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if ({req_valid, req_we, busy, done, pass_o, led, req_addr, req_wdata,
                 fail_addr, fail_exp, fail_got} != '0) idle_bad++;
        end
        check("idle.quiet_cycles", 32'(idle_bad), 32'd0);
        check("idle.led", 32'(led), 32'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

`ifdef SRAM_BIST_INVERT_PASS_EN
        run_vec(vecs[0]);
        check("inv.pass2_addr3", 32'(wr_data_q.size() > 19 ? wr_data_q[19] : 8'h00), 32'h59);
        check("inv.n_wr32", 32'(wr_addr_q.size()), 32'd32);
`endif

        // Randomized flip location checked against the reference pattern
        for (int k = 0; k < 3; k++) begin
            ra = int'($urandom_range(N - 1, 0));
            rp = int'($urandom_range(NPASS, 1));
            rm = 8'h01 << $urandom_range(7, 0);
            rv = mk("rand_flip", 1'b1, 4, ra, rm, rp, 1'b0, ra, pat(ra, rp), pat(ra, rp) ^ rm);
            run_vec(rv);
        end

        // Asynchronous reset in the middle of the write phase, then a clean restart
        stall_en = 1'b0; max_lat = 1; flip_addr = -1;
        pulse_start();
        cyc = 0;
        while (!(req_valid && req_we && req_addr == 4'd7) && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        check("rst_mid.reach_addr7", 32'(req_addr), 32'd7);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid.valid_drop", 32'(req_valid), 32'd0);
        check("rst_mid.busy_drop", 32'(busy), 32'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        run_vec(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
